// File: rtl/regfile_sb.sv
// regfile_sb: multi-port integer register file with write-back scoreboard.
// Registered writes, same-cycle forwarding, busy tracking, debug snapshot.
module regfile_sb #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int NR     = 2,
  parameter int NW     = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NR*AW-1:0]     rd_addr_i,
  output logic [NR*XLEN-1:0]   rd_data_o,
  output logic [NR-1:0]        rd_busy_o,
  input  logic [NW-1:0]        wr_en_i,
  input  logic [NW*AW-1:0]     wr_addr_i,
  input  logic [NW*XLEN-1:0]   wr_data_i,
  input  logic                 iss_en_i,
  input  logic [AW-1:0]        iss_addr_i,
  input  logic                 flush_i,
  output logic [NREG-1:0]      busy_o,
  output logic [AW:0]          busy_cnt_o,
  output logic [NREG*XLEN-1:0] dbg_regs_o
);

  logic [NREG-1:0][XLEN-1:0] regs_q;
  logic [NREG-1:0][XLEN-1:0] regs_d;
  logic [NREG-1:0]           busy_q;
  logic [NREG-1:0]           busy_d;
  logic [AW:0]               cnt_q;
  logic [AW:0]               cnt_d;

  // Next storage: ports applied in index order so the highest one wins.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NW; j++) begin
      if (wr_en_i[j] && wr_addr_i[j*AW +: AW] != '0) begin
        regs_d[wr_addr_i[j*AW +: AW]] = wr_data_i[j*XLEN +: XLEN];
      end
    end
    regs_d[0] = '0;
  end

  // Next busy vector: completion < new issue < flush, x0 never busy.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NW; j++) begin
      if (wr_en_i[j]) begin
        busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
      end
    end
    if (iss_en_i) begin
      busy_d[iss_addr_i] = 1'b1;
    end
    if (flush_i) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  // Popcount of the next busy vector, registered alongside it.
  always_comb begin
    cnt_d = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
    end
  end

  // State update; reset drops data and pending producers alike.
  always_ff @(posedge clk) begin
    if (!rst) begin
      regs_q <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Read ports: stored value, optionally overridden by a same-cycle write.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int k = 0; k < NR; k++) begin
      if (rst && rd_addr_i[k*AW +: AW] != '0) begin
        rd_data_o[k*XLEN +: XLEN] = regs_q[rd_addr_i[k*AW +: AW]];
        rd_busy_o[k] = busy_q[rd_addr_i[k*AW +: AW]];
        if (BYPASS != 0) begin
          for (int j = 0; j < NW; j++) begin
            if (wr_en_i[j] &&
                wr_addr_i[j*AW +: AW] == rd_addr_i[k*AW +: AW]) begin
              rd_data_o[k*XLEN +: XLEN] = wr_data_i[j*XLEN +: XLEN];
              rd_busy_o[k] = 1'b0;
            end
          end
        end
      end
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;
  assign dbg_regs_o = regs_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of regfile_sb, bypass and no-bypass builds.
// Both instances share stimulus; the second one is built with BYPASS=0.
module tb_regfile_sb;

  logic          clk;
  logic          rst;
  logic [9:0]    rd_addr;
  logic [127:0]  rd_data0, rd_data1;
  logic [1:0]    rd_busy0, rd_busy1;
  logic [1:0]    wr_en;
  logic [9:0]    wr_addr;
  logic [127:0]  wr_data;
  logic          iss_en;
  logic [4:0]    iss_addr;
  logic          flush;
  logic [31:0]   busy0, busy1;
  logic [5:0]    cnt0, cnt1;
  logic [2047:0] dbg0, dbg1;

  int checks = 0;
  int failures = 0;

  regfile_sb #(.BYPASS(1)) u_byp (
    .clk(clk), .rst(rst),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data0), .rd_busy_o(rd_busy0),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .iss_en_i(iss_en), .iss_addr_i(iss_addr), .flush_i(flush),
    .busy_o(busy0), .busy_cnt_o(cnt0), .dbg_regs_o(dbg0)
  );

  regfile_sb #(.BYPASS(0)) u_nobyp (
    .clk(clk), .rst(rst),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data1), .rd_busy_o(rd_busy1),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .iss_en_i(iss_en), .iss_addr_i(iss_addr), .flush_i(flush),
    .busy_o(busy1), .busy_cnt_o(cnt1), .dbg_regs_o(dbg1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 2'b00;
    iss_en = 1'b0;
    flush  = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    rd_addr  = {5'd2, 5'd1};
    wr_en    = 2'b11;
    wr_addr  = {5'd2, 5'd1};
    wr_data  = {64'hDEAD, 64'hBEEF};
    iss_en   = 1'b1;
    iss_addr = 5'd2;
    flush    = 1'b0;
    tick();
    tick();
    check("rst_rd0", rd_data0[63:0], 64'h0);
    check("rst_rd1", rd_data0[127:64], 64'h0);
    check("rst_rdbusy", {62'h0, rd_busy0}, 64'h0);

    rst = 1'b1;
    idle();
    #1;
    check("post_rst_rd0", rd_data0[63:0], 64'h0);
    check("post_rst_rd1", rd_data1[127:64], 64'h0);
    check("post_rst_busy", {32'h0, busy0}, 64'h0);
    check("post_rst_cnt", {58'h0, cnt0}, 64'h0);
    check("post_rst_dbg", {63'h0, |dbg0}, 64'h0);

    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd3};
    wr_data = {64'h0, 64'h1122334455667788};
    rd_addr = {5'd3, 5'd0};
    #1;
    check("byp_x3", rd_data0[127:64], 64'h1122334455667788);
    tick();
    idle();
    #1;
    check("stored_x3", rd_data0[127:64], 64'h1122334455667788);
    check("dbg_x3", dbg0[3*64 +: 64], 64'h1122334455667788);

    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd0};
    wr_data = {64'h0, 64'hFFFF};
    rd_addr = {5'd0, 5'd0};
    #1;
    check("byp_x0", rd_data0[63:0], 64'h0);
    tick();
    idle();
    #1;
    check("stored_x0", rd_data0[63:0], 64'h0);
    check("dbg_x0", dbg0[63:0], 64'h0);

    wr_en   = 2'b11;
    wr_addr = {5'd7, 5'd7};
    wr_data = {64'hBBBB, 64'hAAAA};
    rd_addr = {5'd0, 5'd7};
    #1;
    check("prio_byp", rd_data0[63:0], 64'hBBBB);
    tick();
    idle();
    #1;
    check("prio_stored", rd_data0[63:0], 64'hBBBB);
    check("prio_nobyp", rd_data1[63:0], 64'hBBBB);

    iss_en   = 1'b1;
    iss_addr = 5'd9;
    rd_addr  = {5'd0, 5'd9};
    tick();
    idle();
    #1;
    check("iss9_busy", {63'h0, busy0[9]}, 64'h1);
    check("iss9_cnt", {58'h0, cnt0}, 64'h1);
    check("iss9_rdbusy", {63'h0, rd_busy0[0]}, 64'h1);

    wr_en   = 2'b10;
    wr_addr = {5'd9, 5'd0};
    wr_data = {64'h42, 64'h0};
    #1;
    check("wr9_rdbusy_byp", {63'h0, rd_busy0[0]}, 64'h0);
    check("wr9_rdbusy_nobyp", {63'h0, rd_busy1[0]}, 64'h1);
    check("wr9_data_byp", rd_data0[63:0], 64'h42);
    tick();
    idle();
    #1;
    check("wr9_busy", {63'h0, busy0[9]}, 64'h0);
    check("wr9_cnt", {58'h0, cnt0}, 64'h0);

    iss_en   = 1'b1;
    iss_addr = 5'd4;
    wr_en    = 2'b01;
    wr_addr  = {5'd0, 5'd4};
    wr_data  = {64'h0, 64'h5};
    tick();
    idle();
    #1;
    check("coll_busy4", {63'h0, busy0[4]}, 64'h1);
    check("coll_dbg4", dbg0[4*64 +: 64], 64'h5);
    check("coll_cnt", {58'h0, cnt0}, 64'h1);

    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd4};
    wr_data = {64'h0, 64'h5};
    tick();
    idle();
    iss_en   = 1'b1;
    iss_addr = 5'd10;
    tick();
    iss_addr = 5'd11;
    tick();
    iss_addr = 5'd12;
    tick();
    idle();
    #1;
    check("three_cnt", {58'h0, cnt0}, 64'h3);
    check("three_busy", {32'h0, busy0}, 64'h1C00);

    flush    = 1'b1;
    iss_en   = 1'b1;
    iss_addr = 5'd13;
    wr_en    = 2'b01;
    wr_addr  = {5'd0, 5'd14};
    wr_data  = {64'h0, 64'h77};
    tick();
    idle();
    #1;
    check("flush_busy", {32'h0, busy0}, 64'h0);
    check("flush_cnt", {58'h0, cnt0}, 64'h0);
    check("flush_wr14", dbg0[14*64 +: 64], 64'h77);

    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd6};
    wr_data = {64'h0, 64'h99};
    rd_addr = {5'd0, 5'd6};
    #1;
    check("nobyp_old", rd_data1[63:0], 64'h0);
    check("byp_new", rd_data0[63:0], 64'h99);
    tick();
    idle();
    #1;
    check("nobyp_new", rd_data1[63:0], 64'h99);

    iss_en   = 1'b1;
    iss_addr = 5'd20;
    tick();
    idle();
    #1;
    check("pre_rst_cnt", {58'h0, cnt0}, 64'h1);
    rst      = 1'b0;
    iss_en   = 1'b1;
    iss_addr = 5'd21;
    wr_en    = 2'b01;
    wr_addr  = {5'd0, 5'd6};
    wr_data  = {64'h0, 64'h55};
    tick();
    rst = 1'b1;
    idle();
    #1;
    check("mid_rst_busy", {32'h0, busy0}, 64'h0);
    check("mid_rst_cnt", {58'h0, cnt0}, 64'h0);
    check("mid_rst_dbg", {63'h0, |dbg0}, 64'h0);
    check("mid_rst_dbg_nobyp", {63'h0, |dbg1}, 64'h0);
    check("mid_rst_rd6", rd_data1[63:0], 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
